// File: rtl/img_pkg.sv
// Shared constants, operation encodings and FSM state type for the image frame sequencer.
package img_pkg;

    localparam int WIDTH        = 32;
    localparam int HEIGHT       = 32;
    localparam int TOTAL_PIXELS = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        OP_PASS     = 2'b00,
        OP_NEGATE   = 2'b01,
        OP_THRESH   = 2'b10,
        OP_PASS_ALT = 2'b11
    } op_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Per-pixel transform applied just before the destination data register.
    function automatic logic [7:0] pixel_op(input op_mode_e mode, input logic [7:0] thr,
                                            input logic [7:0] p);
        case (mode)
            OP_NEGATE: return 8'd255 - p;
            OP_THRESH: return (p >= thr) ? 8'hFF : 8'h00;
            default:   return p;
        endcase
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous pixel FIFO with occupancy count and a synchronous clear.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array write.
    // NOTE: the data array has no reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
    // NOTE: state is updated with <= so every register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/image_frame_sequencer.sv
// Streams one frame from a source BRAM through a pixel operation into a destination BRAM,
// keeping outstanding reads bounded by the pixel FIFO so back-pressure never loses data.
module image_frame_sequencer #(
    parameter int WIDTH      = img_pkg::WIDTH,
    parameter int HEIGHT     = img_pkg::HEIGHT,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        op_mode,
    input  logic [7:0]        threshold,
    output logic              src_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_dout,
    input  logic              dst_ready,
    output logic              dst_we,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_din,
    output logic              busy,
    output logic              done
);

    import img_pkg::*;

    localparam int                FRAME_PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);
    localparam int                CNT_W        = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    op_mode_e          mode_q;
    logic [7:0]        thr_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [RD_LAT-1:0] inflight_q;
    logic              src_en_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic              dst_we_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [7:0]        dst_din_q;
    logic              done_q;

    logic [7:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic              abort_now;
    logic              push_now;
    logic              pop_now;
    logic [RD_LAT-1:0] inflight_d;
    int                occ_d;
    logic              room_d;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort_now),
        .push  (push_now),
        .din   (src_dout),
        .pop   (pop_now),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Flow control: issue another read only if, after this edge, the FIFO plus reads
    // still in the BRAM pipeline leave a free slot for it.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        abort_now  = abort && (state_q != ST_IDLE);
        push_now   = inflight_q[RD_LAT-1];
        pop_now    = !fifo_empty && dst_ready && !abort_now;
        inflight_d = RD_LAT'({inflight_q, src_en_q});
        occ_d      = int'(fifo_count) + int'(push_now) - int'(pop_now) + $countones(inflight_d);
        room_d     = (occ_d < FIFO_DEPTH);
    end

    // Frame FSM with registered read/write ports and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= OP_PASS;
            thr_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= '0;
            src_en_q   <= 1'b0;
            src_addr_q <= '0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_din_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            src_en_q   <= 1'b0;
            src_addr_q <= '0;
            dst_we_q   <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= inflight_d;

            if (pop_now) begin
                dst_we_q   <= 1'b1;
                dst_addr_q <= wr_cnt_q;
                dst_din_q  <= pixel_op(mode_q, thr_q, fifo_head);
                if (wr_cnt_q != LAST_ADDR) wr_cnt_q <= wr_cnt_q + 1'b1;
            end

            if (abort_now) begin
                state_q    <= ST_IDLE;
                inflight_q <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q  <= ST_RUN;
                            mode_q   <= op_mode_e'(op_mode);
                            thr_q    <= threshold;
                            rd_cnt_q <= '0;
                            wr_cnt_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (room_d) begin
                            src_en_q   <= 1'b1;
                            src_addr_q <= rd_cnt_q;
                            if (rd_cnt_q == LAST_ADDR) state_q  <= ST_DRAIN;
                            else                       rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (pop_now && (wr_cnt_q == LAST_ADDR)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign src_en   = src_en_q;
    assign src_addr = src_addr_q;
    assign dst_we   = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_din  = dst_din_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: doc/image_frame_sequencer.md
IMAGE_FRAME_SEQUENCER -- requirements
Module: image_frame_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, image width in pixels.
REQ-002 Parameter HEIGHT, default 32, image height in pixels; TOTAL_PIXELS = WIDTH*HEIGHT.
REQ-003 Parameter ADDR_W, default 16, BRAM address width.
REQ-004 Parameter RD_LAT, default 2, source BRAM read latency in cycles.
REQ-005 Parameter FIFO_DEPTH, default 4, pixel buffer depth; SHALL be at least RD_LAT+2.
REQ-006 Port clk, input, 1, single clock for the whole block, rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, frame request, sampled only in IDLE.
REQ-009 Port abort, input, 1, cancel the current frame.
REQ-010 Port op_mode, input, 2, pixel operation: 00 pass, 01 negate, 10 threshold, 11 pass.
REQ-011 Port threshold, input, 8, threshold value for op_mode 10.
REQ-012 Port src_en / src_addr, output, 1 / ADDR_W, source BRAM read enable and address.
REQ-013 Port src_dout, input, 8, source BRAM read data, valid RD_LAT cycles after src_en.
REQ-014 Port dst_ready, input, 1, destination can accept a write this cycle.
REQ-015 Port dst_we / dst_addr / dst_din, output, 1 / ADDR_W / 8, registered destination write.
REQ-016 Port busy, output, 1, high in every state except IDLE.
REQ-017 Port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN on start=1; op_mode and threshold are latched on that edge, and read and write counters are cleared.
REQ-020 RUN issues src_en=1 with src_addr=rd_cnt only when fifo_count+inflight < FIFO_DEPTH; rd_cnt then increments.
REQ-021 RUN->DRAIN on the edge that issues read TOTAL_PIXELS-1.
REQ-022 inflight is a RD_LAT-deep valid shift register; src_dout is pushed into the FIFO when the valid bit emerges.
REQ-023 Any edge with FIFO non-empty and dst_ready=1 pops the head and registers dst_we=1, dst_addr=wr_cnt and dst_din=f(head); wr_cnt then increments. Otherwise dst_we=0, and dst_addr/dst_din hold.
REQ-024 f: pass = p; negate = 255-p; threshold = (p >= threshold) ? 255 : 0.
REQ-025 DRAIN->DONE on the edge that issues write TOTAL_PIXELS-1; DONE lasts one cycle with done=1, then goes to IDLE.
REQ-026 Latency with dst_ready=1: read issued in cycle t produces dst_we in cycle t+RD_LAT+2; sustained rate is 1 pixel/clk.
REQ-027 A push and a pop in the same cycle at any occupancy leave fifo_count unchanged; the FIFO never overflows.
REQ-028 start is ignored outside IDLE; abort is ignored in IDLE.
REQ-029 abort in RUN/DRAIN/DONE: next state IDLE; FIFO and inflight cleared; dst_we=0; done not pulsed.
REQ-030 Read and write addresses never exceed TOTAL_PIXELS-1; counters do not wrap within a frame.
REQ-031 src_addr=0 whenever src_en=0.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE and clears all counters, FIFO pointers and inflight.
REQ-033 While rst_n=0, all outputs SHALL be 0.
REQ-034 Reset mid-frame discards the frame; the first start after release begins at address 0.

Structure
REQ-035 Package img_pkg holds WIDTH, HEIGHT, TOTAL_PIXELS, the op_mode encodings and the FSM state typedef.
REQ-036 Sub-module pixel_fifo: synchronous FIFO, FIFO_DEPTH x 8, with push, pop, count, empty and full, reset by rst_n.
REQ-037 The pixel operation is combinational logic in front of the dst_din register.

Verification
REQ-038 Source holds addr[7:0], op_mode=01, dst_ready=1, start pulse -> 1024 writes with dst_din[k]=~k[7:0], one per clock after a 4-cycle fill, then exactly one done.
REQ-039 dst_ready=0 for 20 cycles from write 300 -> src_en stalls within 4 outstanding reads; no pixel is lost, duplicated or reordered, and writes resume at dst_addr 300.
REQ-040 op_mode=10, threshold=128 -> pixel 127 writes 0, pixel 128 writes 255, pixel 255 writes 255.
REQ-041 start re-pulsed at write 100 -> ignored and the frame completes unchanged; abort at write 500 then start -> dst_we drops next cycle with no done, and the new frame restarts at addresses 0/0.
REQ-042 rst_n low at write 700 -> all outputs 0 immediately; after release, start runs a full clean frame.
REQ-043 Random dst_ready with 50% duty over 3 frames -> destination contents match the reference model and done count equals 3.
